// File: rtl/approx_mult_pipe.sv
// Three-stage signed multiplier with a per-operation choice of exact or approximate mode.
// In approximate mode the partial-product columns below APPROX_LSB are ORed instead of added.
module approx_mult_pipe #(
  parameter int A_W        = 22,
  parameter int B_W        = 16,
  parameter int APPROX_LSB = 16,
  localparam int OUT_W     = A_W + B_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_en,
  input  logic             in_valid,
  input  logic [A_W-1:0]   a,
  input  logic [B_W-1:0]   b,
  input  logic             precise_en,
  output logic             out_valid,
  output logic             out_precise,
  output logic [OUT_W-1:0] product
);

  localparam int LA = A_W / 2;
  localparam int LB = B_W / 2;

  logic [A_W-1:0] abs_a;
  logic [B_W-1:0] abs_b;

  // The most negative input still fits: its magnitude is 2^(W-1) in W unsigned bits.
  assign abs_a = a[A_W-1] ? (~a + A_W'(1)) : a;
  assign abs_b = b[B_W-1] ? (~b + B_W'(1)) : b;

  logic           s1_valid;
  logic           s1_sign;
  logic           s1_precise;
  logic [A_W-1:0] s1_mag_a;
  logic [B_W-1:0] s1_mag_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_sign    <= 1'b0;
      s1_precise <= 1'b0;
      s1_mag_a   <= '0;
      s1_mag_b   <= '0;
    end else if (clk_en) begin
      s1_valid   <= in_valid;
      s1_sign    <= a[A_W-1] ^ b[B_W-1];
      s1_precise <= precise_en;
      s1_mag_a   <= abs_a;
      s1_mag_b   <= abs_b;
    end
  end

  logic [LA-1:0]     a_lo;
  logic [A_W-LA-1:0] a_hi;
  logic [LB-1:0]     b_lo;
  logic [B_W-LB-1:0] b_hi;
  logic [OUT_W-1:0]  p0, p1, p2, p3;
  logic [OUT_W-1:0]  m_exact;
  logic [OUT_W-1:0]  m_approx;

  assign a_lo = s1_mag_a[LA-1:0];
  assign a_hi = s1_mag_a[A_W-1:LA];
  assign b_lo = s1_mag_b[LB-1:0];
  assign b_hi = s1_mag_b[B_W-1:LB];

  assign p0 = OUT_W'(a_lo) * OUT_W'(b_lo);
  assign p1 = (OUT_W'(a_hi) * OUT_W'(b_lo)) << LA;
  assign p2 = (OUT_W'(a_lo) * OUT_W'(b_hi)) << LB;
  assign p3 = (OUT_W'(a_hi) * OUT_W'(b_hi)) << (LA + LB);

  assign m_exact = p0 + p1 + p2 + p3;

  // Upper columns are summed independently, so no carry leaks up from the ORed region.
  if (APPROX_LSB == 0) begin : g_no_approx
    assign m_approx = m_exact;
  end else if (APPROX_LSB >= OUT_W) begin : g_all_or
    assign m_approx = p0 | p1 | p2 | p3;
  end else begin : g_split
    localparam int HW = OUT_W - APPROX_LSB;
    logic [HW-1:0]         hi_sum;
    logic [APPROX_LSB-1:0] lo_or;
    assign hi_sum = HW'(p0 >> APPROX_LSB) + HW'(p1 >> APPROX_LSB)
                  + HW'(p2 >> APPROX_LSB) + HW'(p3 >> APPROX_LSB);
    assign lo_or  = p0[APPROX_LSB-1:0] | p1[APPROX_LSB-1:0]
                  | p2[APPROX_LSB-1:0] | p3[APPROX_LSB-1:0];
    assign m_approx = {hi_sum, lo_or};
  end

  logic             s2_valid;
  logic             s2_sign;
  logic             s2_precise;
  logic [OUT_W-1:0] s2_mag;

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid   <= 1'b0;
      s2_sign    <= 1'b0;
      s2_precise <= 1'b0;
      s2_mag     <= '0;
    end else if (clk_en) begin
      s2_valid   <= s1_valid;
      s2_sign    <= s1_sign;
      s2_precise <= s1_precise;
      s2_mag     <= s1_precise ? m_exact : m_approx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_precise <= 1'b0;
      product     <= '0;
    end else if (clk_en) begin
      out_valid   <= s2_valid;
      out_precise <= s2_precise;
      product     <= s2_sign ? (~s2_mag + OUT_W'(1)) : s2_mag;
    end
  end

endmodule

// File: doc/approx_mult_pipe.md
# approx_mult_pipe

Parametrised, pipelined signed approximate multiplier for the IDCT/motion-compensation datapath. It computes a full-width two's-complement product of two signed operands, selectable per operation between exact and approximate modes. In approximate mode, partial-product columns below a configurable boundary are combined with OR instead of addition. It replaces fixed-width, single-register approximate multipliers with a valid-tagged 3-stage pipeline that is correctly signed, stallable and usable at any operand width.

## Interface
Parameters:
- A_W, 22: width of signed operand a (≥2).
- B_W, 16: width of signed operand b (≥2).
- APPROX_LSB, 16: number of product LSB columns combined by OR in approximate mode; range 0..A_W+B_W.
- OUT_W: derived, fixed at A_W+B_W; not overridable.

Ports:
- clk, in, 1: single clock.
- rst, in, 1: reset, synchronous, active-high.
- clk_en, in, 1: pipeline advance enable.
- in_valid, in, 1: operand qualifier.
- a, in, A_W: signed multiplicand.
- b, in, B_W: signed multiplier.
- precise_en, in, 1: 1 selects exact product, 0 selects approximate; sampled with operands.
- out_valid, out, 1: product qualifier.
- out_precise, out, 1: mode tag of the emitted product.
- product, out, OUT_W: signed result.

## Operation
- Stage 1 (S1) registers sign = a[A_W-1]^b[B_W-1], |a| (A_W bits unsigned), |b| (B_W bits unsigned), mode and valid. The most-negative input magnitude 2^(W-1) is representable; no saturation.
- Stage 2 (S2) forms the magnitude product. LA = A_W/2 (floor) and LB = B_W/2 (floor). Split aL = |a|[LA-1:0], aH = |a|>>LA, bL = |b|[LB-1:0], bH = |b|>>LB.
- S2 partial products, each OUT_W bits:
  - p0 = aL*bL
  - p1 = (aH*bL)<<LA
  - p2 = (aL*bH)<<LB
  - p3 = (aH*bH)<<(LA+LB)
- Precise mode: M = p0+p1+p2+p3, which equals |a|*|b|.
- Approximate mode:
  - M[APPROX_LSB-1:0] = (p0|p1|p2|p3)[APPROX_LSB-1:0].
  - M[OUT_W-1:APPROX_LSB] = sum of (pi>>APPROX_LSB) over all four partial products.
  - No carry crosses the boundary.
- Boundary cases:
  - APPROX_LSB=0 makes both modes identical.
  - APPROX_LSB=OUT_W makes the approximate result the pure OR of the partial products.
- M never exceeds OUT_W bits in either mode (approx ≤ exact ≤ 2^(OUT_W-2)); no overflow logic is required.
- Stage 3 (S3): product = sign ? (~M+1) mod 2^OUT_W : M. A zero magnitude yields 0 regardless of sign.
- The mode is carried per operation alongside valid. Mixing modes back-to-back is legal and each result uses its own tag.
- Invalid slots flow through. out_valid=0 slots hold an unspecified product; the bench ignores product when out_valid=0.

## Timing
- Latency: exactly 3 enabled cycles. Operands accepted on enabled edge N appear on outputs after enabled edge N+2, and are visible the cycle after that edge.
- Throughput: one operation per enabled cycle; no backpressure output.
- clk_en=0: every pipeline register, including valid and mode tags, holds its value, and outputs are stable. in_valid is ignored while clk_en=0.
- Reset:
  - rst=1 at an edge clears all valid bits, out_valid, out_precise and product to 0, regardless of clk_en.
  - In-flight operations are discarded.
  - The first operand accepted after rst deasserts emerges 3 enabled cycles later.
- Simultaneous rst and in_valid: rst wins and the operand is dropped.

## Test plan
Defaults A_W=22, B_W=16, APPROX_LSB=16.
- Precise small signed: a=-3, b=5, precise_en=1 -> 3 enabled cycles later out_valid=1, product=0x3FFFFFFFF1 (-15), out_precise=1.
- Approximate with overlapping columns: a=0xFFF, b=0x1FF, precise_en=0 -> product=0x1DFF01 (exact would be 0x1FEE01). Same operands with a=-0xFFF -> 0x3FFFE200FF. Same operands with precise_en=1 -> 0x1FEE01.
- Extremes: a=-2^21, b=-2^15 in both modes -> product=0x1000000000 (2^36). a=-5, b=0 -> product=0.
- Back-to-back mixed modes: 4 consecutive valid ops alternating precise_en, using the pairs above -> 4 consecutive out_valid cycles. Each product and out_precise matches its own mode.
- Stall: drop clk_en for 2 cycles while 3 ops are in flight -> outputs frozen during the stall. Results emerge in order with no loss or duplication.
- Mid-stream reset: rst for 1 cycle with 2 ops in flight -> next edge shows out_valid=0 and product=0. No stale result appears. A new op issued after reset emerges 3 enabled cycles later.
- Randomised sweep: the scoreboard models the partial-product equations exactly. Run at APPROX_LSB of 0, 16 and 38, plus a second build at A_W=12, B_W=12.
